// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a sequential clear
// engine. Storage has no reset; after reset (or clear_req) the clear engine
// walks every entry writing zero, and the file reports ready once done.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [NREGS-1:0] rf_we;
  logic [XLEN-1:0] rf_wd [NREGS];

  logic            wr_open;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;

  // An address is usable when it names a real register and is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes only land in RUN and never in the cycle a clear is requested.
  assign wr_open = (state_q == ST_RUN) && !clear_req;
  assign ready   = ready_q;

  // Next-state logic: walk the clear index to the last register, then run
  // until a clear is requested.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        if (32'(idx_q) == 32'(NREGS - 1)) begin
          state_d = ST_RUN;
          idx_d   = '0;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset restarts the clear sequence from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Per-register write decode; ports are scanned low to high so the
  // highest-numbered port wins a same-address conflict.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rf_we[r] = 1'b0;
      rf_wd[r] = '0;
    end
    if (state_q == ST_CLEAR) begin
      for (int r = 0; r < NREGS; r++) begin
        if (32'(idx_q) == 32'(r)) rf_we[r] = 1'b1;
      end
    end else if (wr_open) begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && addr_ok(wa[i*AW +: AW])) begin
          for (int r = 0; r < NREGS; r++) begin
            if (32'(wa[i*AW +: AW]) == 32'(r)) begin
              rf_we[r] = 1'b1;
              rf_wd[r] = wd[i*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  // Storage array: no reset, contents come from the clear engine.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rf_we[r]) rf_q[r] <= rf_wd[r];
    end
  end

  // Combinational read lanes with optional same-cycle bypass; everything
  // reads zero while the clear engine is active.
  always_comb begin
    rd      = '0;
    rd_addr = '0;
    rd_val  = '0;
    if (state_q == ST_RUN) begin
      for (int j = 0; j < NRD; j++) begin
        rd_addr = ra[j*AW +: AW];
        rd_val  = '0;
        if (addr_ok(rd_addr)) begin
          rd_val = rf_q[rd_addr];
          if ((BYPASS != 0) && wr_open) begin
            for (int i = 0; i < NWR; i++) begin
              if (we[i] && addr_ok(wa[i*AW +: AW]) && (wa[i*AW +: AW] == rd_addr))
                rd_val = wd[i*XLEN +: XLEN];
            end
          end
        end
        rd[j*XLEN +: XLEN] = rd_val;
      end
    end
  end

endmodule
